din_pacer: RTL and testbench
============================

Name: din_pacer

Overview:
- Stream source stage that sits directly upstream of the test_din consumer and drives its din_valid/din_data pair.
- Accepts words from a ready/valid producer and stores them in a small FIFO.
- Emits them as a valid-only stream (no backpressure), with a programmable number of idle cycles between words.
- Lets benches and system logic pace traffic into test_din deterministically.

Parameters:
- DWIDTH, 16, data width; matches test_din DWIDTH.
- DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
- GAP_WIDTH, 8, width of the inter-word gap configuration.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- up_valid  in  1  upstream word valid.
- up_ready  out  1  FIFO can accept; equals (level != DEPTH), combinational from registered level.
- up_data  in  DWIDTH  upstream word.
- cfg_en  in  1  output enable; gates pops only.
- cfg_gap  in  GAP_WIDTH  idle cycles inserted after each emitted word.
- din_valid  out  1  registered; one cycle per emitted word.
- din_data  out  DWIDTH  registered; holds last emitted value when din_valid=0.
- fifo_level  out  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
- busy  out  1  (state != IDLE) or (fifo_level != 0).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset state:
  - din_valid=0, din_data=0, fifo_level=0, pointers=0, state=IDLE, gap_cnt=0.
  - Reset dominates all other events.
  - up_ready reads 1 during reset (level 0), but writes in reset cycles are discarded.
- Push:
  - Occurs on up_valid & up_ready.
  - No write when full, even if a pop occurs in the same cycle (no pass-through).
- Pop:
  - Occurs only when level > 0, evaluated on registered level.
  - A word written in cycle t is poppable at the earliest in cycle t+1.
  - Minimum latency from accept to din_valid is 2 cycles.
- Simultaneous push and pop (not full, not empty): level unchanged; order preserved.
- Pop decision: pop = cfg_en & (level != 0) & (state == IDLE, or EMIT with cfg_gap == 0, or GAP with gap_cnt == 0).
  - A pop registers din_valid=1 and din_data=head on the next edge, and enters EMIT.
- FSM IDLE:
  - Pop → EMIT; otherwise stay in IDLE with din_valid=0.
- FSM EMIT (din_valid=1 this cycle; cfg_gap sampled here):
  - cfg_gap == 0: if pop → EMIT (back-to-back), else → IDLE.
  - cfg_gap > 0: → GAP, gap_cnt <= cfg_gap-1.
- FSM GAP (din_valid=0):
  - gap_cnt != 0: decrement.
  - gap_cnt == 0: if pop → EMIT, else → IDLE.
  - GAP therefore lasts exactly cfg_gap cycles.
- cfg_en deassertion:
  - Never truncates an EMIT cycle or a GAP.
  - Only blocks the next pop; the FSM returns to IDLE and the FIFO holds its words.
- Pointers: DEPTH is a power of 2, so pointers wrap naturally at DEPTH.
- cfg_gap maximum: 2^GAP_WIDTH-1; no saturation logic needed.

Optional Feature:
- Macro DIN_PACER_STAT_EN.
- When defined, two ports are added:
  - word_cnt out 32: counts din_valid cycles; wraps at 2^32; reset 0.
  - ovf_seen out 1: sticky, set when up_valid & ~up_ready; cleared only by reset.
- When undefined, both ports and their logic are absent; core behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles with up_valid=1, up_data=0xAAAA → din_valid=0, din_data=0, fifo_level=0 after release; no 0xAAAA ever emitted.
- Back-to-back: cfg_en=1, cfg_gap=0, push 0x0001..0x0004 on consecutive cycles from cycle t → din_valid=1 for cycles t+2..t+5 with data 1,2,3,4; then IDLE, busy=0.
- Pacing: cfg_gap=3, three words queued, cfg_en raised → din_valid pattern 1,0,0,0,1,0,0,0,1 with data in order; then IDLE.
- Full: DEPTH=8, cfg_en=0, present 10 words 0..9 → 8 accepted, up_ready=0 after 8th, fifo_level=8; with STAT_EN, ovf_seen=1. Enable → words 0..7 emitted in order, word_cnt=8.
- Enable drop: cfg_gap=0, 5 words queued; deassert cfg_en in the cycle of the 2nd din_valid → exactly 2 words emitted, fifo_level=3; re-enable → words 3..5 follow.
- Reset mid-operation: assert rst_n=0 during GAP with 3 words queued → next cycle din_valid=0, fifo_level=0, state IDLE; after release with cfg_en=1, no stale word emitted.

Source files
------------

// File: rtl/din_pacer.sv
// Paced valid-only stream source: ready/valid words buffer in a FIFO and leave with cfg_gap idle cycles between them.
// Optional DIN_PACER_STAT_EN adds word_cnt/ovf_seen statistics ports.
module din_pacer #(
  parameter int DWIDTH    = 16,
  parameter int DEPTH     = 8,
  parameter int GAP_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_valid,
  output logic                       up_ready,
  input  logic [DWIDTH-1:0]          up_data,
  input  logic                       cfg_en,
  input  logic [GAP_WIDTH-1:0]       cfg_gap,
  output logic                       din_valid,
  output logic [DWIDTH-1:0]          din_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy
`ifdef DIN_PACER_STAT_EN
  ,output logic [31:0]               word_cnt,
  output logic                       ovf_seen
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t                state;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DWIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop, slot_free;

  assign up_ready = (fifo_level != LW'(DEPTH));
  assign push     = up_valid & up_ready;
  assign busy     = (state != IDLE) | (fifo_level != '0);

  // A pop is allowed only at a slot boundary: idle, a zero-gap emit, or the last gap cycle.
  always_comb begin
    slot_free = 1'b0;
    case (state)
      IDLE:    slot_free = 1'b1;
      EMIT:    slot_free = (cfg_gap == '0);
      GAP:     slot_free = (gap_cnt == '0);
      default: slot_free = 1'b0;
    endcase
  end
  assign pop = cfg_en & (fifo_level != '0) & slot_free;

  // Storage carries no reset; writes are dropped while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= up_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      din_valid  <= 1'b0;
      din_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        din_data <= mem[rd_ptr];
      end
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      din_valid  <= pop;
      case (state)
        IDLE: if (pop) state <= EMIT;
        EMIT: begin
          if (cfg_gap == '0) begin
            state <= pop ? EMIT : IDLE;
          end else begin
            state   <= GAP;
            gap_cnt <= cfg_gap - GAP_WIDTH'(1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          else               state   <= pop ? EMIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIN_PACER_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
      ovf_seen <= 1'b0;
    end else begin
      word_cnt <= word_cnt + 32'(din_valid);
      if (up_valid & ~up_ready) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_din_pacer.sv
// Self-checking bench for din_pacer: scoreboard for emitted data, per-scenario tasks for timing.
module tb_din_pacer;
  localparam int DW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic          cfg_en;
  logic [GW-1:0] cfg_gap;
  logic          din_valid;
  logic [DW-1:0] din_data;
  logic [3:0]    fifo_level;
  logic          busy;
`ifdef DIN_PACER_STAT_EN
  logic [31:0]   word_cnt;
  logic          ovf_seen;
`endif

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] sb[$];

  din_pacer #(.DWIDTH(DW), .DEPTH(8), .GAP_WIDTH(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .cfg_en(cfg_en), .cfg_gap(cfg_gap),
    .din_valid(din_valid), .din_data(din_data),
    .fifo_level(fifo_level), .busy(busy)
`ifdef DIN_PACER_STAT_EN
    , .word_cnt(word_cnt), .ovf_seen(ovf_seen)
`endif
  );

  always #5 clk = ~clk;

  // Every emitted word must match the next expected scoreboard entry.
  always @(negedge clk) begin
    if (din_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0)
        $display("FAIL sb_unexpected: got word %h, want none", din_data);
      else begin
        logic [DW-1:0] exp_d;
        exp_d = sb.pop_front();
        if (din_data !== exp_d) $display("FAIL sb_data: got %h want %h", din_data, exp_d);
        else passed++;
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; up_valid = 1'b0; cfg_en = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = base + DW'(k);
      sb.push_back(base + DW'(k));
    end
    @(posedge clk); #1 up_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; up_valid = 1'b1; up_data = 16'hAAAA; cfg_en = 1'b1; cfg_gap = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (up_ready !== 1'b1) $display("FAIL rst_up_ready: got %b want 1", up_ready); else passed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; up_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({din_valid, din_data, fifo_level, busy} !== {1'b0, 16'h0, 4'd0, 1'b0})
      $display("FAIL rst_state: got v=%b d=%h lvl=%0d busy=%b want 0/0000/0/0", din_valid, din_data, fifo_level, busy);
    else passed++;
`ifdef DIN_PACER_STAT_EN
    checks++;
    if ({word_cnt, ovf_seen} !== 33'd0) $display("FAIL rst_stat: got cnt=%0d ovf=%b want 0/0", word_cnt, ovf_seen);
    else passed++;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (din_valid !== 1'b0) $display("FAIL rst_no_emit: got din_valid=%b want 0", din_valid); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    cfg_en = 1'b1; cfg_gap = '0;
    for (int i = 0; i < 8; i++) begin
      logic exp_v;
      @(posedge clk); #1;
      if (i < 4) begin
        up_valid = 1'b1; up_data = DW'(i + 1); sb.push_back(DW'(i + 1));
      end else up_valid = 1'b0;
      exp_v = (i >= 2 && i <= 5);
      @(negedge clk);
      checks++;
      if (din_valid !== exp_v) $display("FAIL b2b_valid[%0d]: got %b want %b", i, din_valid, exp_v); else passed++;
    end
    checks++;
    if ({busy, fifo_level} !== 5'd0) $display("FAIL b2b_idle: got busy=%b lvl=%0d want 0/0", busy, fifo_level);
    else passed++;
  endtask

  task automatic test_pacing;
    cfg_en = 1'b0; cfg_gap = 8'd3;
    push_words(3, 16'h0100);
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd3) $display("FAIL pace_level: got %0d want 3", fifo_level); else passed++;
    for (int i = 0; i < 14; i++) begin
      logic exp_v;
      @(posedge clk); #1 cfg_en = 1'b1;
      exp_v = (i == 1 || i == 5 || i == 9);
      @(negedge clk);
      checks++;
      if (din_valid !== exp_v) $display("FAIL pace_valid[%0d]: got %b want %b", i, din_valid, exp_v); else passed++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL pace_idle: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_full;
    do_reset(2);
    cfg_en = 1'b0; cfg_gap = '0;
    for (int i = 0; i < 10; i++) begin
      logic exp_r;
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = DW'(i);
      if (i < 8) sb.push_back(DW'(i));
      exp_r = (i < 8);
      @(negedge clk);
      checks++;
      if (up_ready !== exp_r) $display("FAIL full_ready[%0d]: got %b want %b", i, up_ready, exp_r); else passed++;
    end
    @(posedge clk); #1 up_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8) $display("FAIL full_level: got %0d want 8", fifo_level); else passed++;
`ifdef DIN_PACER_STAT_EN
    checks++;
    if (ovf_seen !== 1'b1) $display("FAIL full_ovf: got %b want 1", ovf_seen); else passed++;
`endif
    for (int i = 0; i < 12; i++) begin
      logic exp_v;
      @(posedge clk); #1 cfg_en = 1'b1;
      exp_v = (i >= 1 && i <= 8);
      @(negedge clk);
      checks++;
      if (din_valid !== exp_v) $display("FAIL full_valid[%0d]: got %b want %b", i, din_valid, exp_v); else passed++;
    end
    checks++;
    if (fifo_level !== 4'd0) $display("FAIL full_drain: got %0d want 0", fifo_level); else passed++;
`ifdef DIN_PACER_STAT_EN
    checks++;
    if (word_cnt !== 32'd8) $display("FAIL full_word_cnt: got %0d want 8", word_cnt); else passed++;
`endif
  endtask

  task automatic test_enable_drop;
    cfg_en = 1'b0; cfg_gap = '0;
    push_words(5, 16'h0001);
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd5) $display("FAIL drop_level0: got %0d want 5", fifo_level); else passed++;
    for (int i = 0; i < 6; i++) begin
      logic exp_v;
      @(posedge clk); #1 cfg_en = (i < 2);
      exp_v = (i == 1 || i == 2);
      @(negedge clk);
      checks++;
      if (din_valid !== exp_v) $display("FAIL drop_valid[%0d]: got %b want %b", i, din_valid, exp_v); else passed++;
    end
    checks++;
    if (fifo_level !== 4'd3) $display("FAIL drop_level: got %0d want 3", fifo_level); else passed++;
    for (int i = 0; i < 6; i++) begin
      logic exp_v;
      @(posedge clk); #1 cfg_en = 1'b1;
      exp_v = (i >= 1 && i <= 3);
      @(negedge clk);
      checks++;
      if (din_valid !== exp_v) $display("FAIL resume_valid[%0d]: got %b want %b", i, din_valid, exp_v); else passed++;
    end
    checks++;
    if ({busy, fifo_level} !== 5'd0) $display("FAIL resume_idle: got busy=%b lvl=%0d want 0/0", busy, fifo_level);
    else passed++;
  endtask

  task automatic test_reset_mid;
    cfg_en = 1'b0; cfg_gap = 8'd3;
    push_words(4, 16'h0200);
    @(posedge clk); #1 cfg_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (din_valid !== 1'b1) $display("FAIL mid_first: got %b want 1", din_valid); else passed++;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, fifo_level} !== {1'b1, 4'd3}) $display("FAIL mid_gap: got busy=%b lvl=%0d want 1/3", busy, fifo_level);
    else passed++;
    @(negedge clk);
    checks++;
    if ({din_valid, fifo_level, busy} !== 6'd0)
      $display("FAIL mid_rst: got v=%b lvl=%0d busy=%b want 0/0/0", din_valid, fifo_level, busy);
    else passed++;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (din_valid !== 1'b0) $display("FAIL mid_stale[%0d]: got %b want 0", i, din_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pacing();
    test_full();
    test_enable_drop();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
